// File: rtl/matmul_wb_accel_if.sv
// Wishbone slave bus bundle for the matrix-multiply accelerator.
//   wbs_cyc_i  bus cycle valid           wbs_stb_i  strobe
//   wbs_we_i   1 = write                 wbs_sel_i  byte lanes
//   wbs_adr_i  byte address              wbs_dat_i  write data
//   wbs_ack_o  one-cycle acknowledge     wbs_dat_o  read data (valid with ack)
// slave modport: accelerator side; master modport: firmware/bench side.
interface matmul_wb_accel_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/matmul_wb_accel.sv
// Wishbone-slave integer matrix-multiply accelerator (C = A x B, NxN).
// One signed MAC per cycle, sequential over (i, j, k); all storage in flops.
// Ports:
//   wb_clk_i  single rising-edge clock
//   wb_rst_i  asynchronous active-high reset
//   wbs       Wishbone slave bundle (matmul_wb_accel_if.slave)
//   irq_o     level interrupt = DONE & IRQ_EN
// Register map (offset = adr[11:0]):
//   0x000 CTRL   bit0 START (write-1 pulse), bit1 IRQ_EN (rw)
//   0x004 STATUS bit0 BUSY (ro), bit1 DONE (sticky, write-1-clears)
//   0x008 CYCLES run length of the last run (ro)
//   0x100 A[i][j], 0x200 B[i][j] at +4*(i*N+j), 16-bit, reads sign-extended
//   0x300 C[i][j] at +4*(i*N+j), ro
//
// state | meaning
// IDLE  | waiting for START; A/B writable
// RUN   | one MAC per cycle over (i,j,k); A/B and START writes ignored
module matmul_wb_accel #(
  parameter int          N         = 4,
  parameter int          DATA_W    = 16,
  parameter int          ACC_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  matmul_wb_accel_if.slave   wbs,
  output logic               irq_o
);

  localparam int              CW     = $clog2(N);
  localparam int              IDX_W  = $clog2(N * N);
  localparam int              MEM_SZ = 1 << IDX_W;
  localparam logic [CW-1:0]   LAST   = CW'(N - 1);
  localparam logic [IDX_W-1:0] N_I   = IDX_W'(N);
  localparam logic [6:0]      MEM_N  = 7'(N * N);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t state_q, state_d;

  logic               ack_q;
  logic [31:0]        dat_q;
  logic               irq_en_q;
  logic               done_q;
  logic [31:0]        cycles_q;
  logic [CW-1:0]      i_q, j_q, k_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [DATA_W-1:0] a_mem [MEM_SZ];
  logic signed [DATA_W-1:0] b_mem [MEM_SZ];
  logic signed [ACC_W-1:0]  c_mem [MEM_SZ];

  // ---------------------------------------------------------------
  // Bus decode. A new request is only taken while ack is low, which
  // gives the every-other-cycle ack pattern for back-to-back requests.
  // ---------------------------------------------------------------
  logic             hit, req, wr_req;
  logic [11:0]      off;
  logic [5:0]       slot;
  logic             slot_ok;
  logic [IDX_W-1:0] slot_idx;
  logic             sel_a, sel_b, sel_c, sel_ctrl, sel_stat, sel_cyc;
  logic             busy;

  assign off      = wbs.wbs_adr_i[11:0];
  assign hit      = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req      = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & ~ack_q;
  assign wr_req   = req & wbs.wbs_we_i;
  assign slot     = off[7:2];
  assign slot_ok  = ({1'b0, slot} < MEM_N);
  assign slot_idx = slot[IDX_W-1:0];
  assign sel_a    = (off[11:8] == 4'h1) & slot_ok;
  assign sel_b    = (off[11:8] == 4'h2) & slot_ok;
  assign sel_c    = (off[11:8] == 4'h3) & slot_ok;
  assign sel_ctrl = (off == 12'h000);
  assign sel_stat = (off == 12'h004);
  assign sel_cyc  = (off == 12'h008);
  assign busy     = (state_q == ST_RUN);

  logic start_req;
  assign start_req = wr_req & sel_ctrl & wbs.wbs_dat_i[0] & ~busy;

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs.wbs_adr_i[1:0], wbs.wbs_sel_i[3:2],
                         wbs.wbs_dat_i[31:DATA_W]};

  // ---------------------------------------------------------------
  // MAC datapath
  // ---------------------------------------------------------------
  logic [IDX_W-1:0]         a_idx, b_idx, c_idx;
  logic signed [ACC_W-1:0]  prod, acc_next;

  assign a_idx    = IDX_W'(i_q) * N_I + IDX_W'(k_q);
  assign b_idx    = IDX_W'(k_q) * N_I + IDX_W'(j_q);
  assign c_idx    = IDX_W'(i_q) * N_I + IDX_W'(j_q);
  assign prod     = ACC_W'(a_mem[a_idx]) * ACC_W'(b_mem[b_idx]);
  assign acc_next = acc_q + prod;

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  logic run_last;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    run_last = 1'b0;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_RUN;
      ST_RUN: begin
        if ((k_q == LAST) && (j_q == LAST) && (i_q == LAST)) begin
          state_d  = ST_IDLE;
          run_last = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Loop counters, accumulator, cycle counter, C storage
  // ---------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      cycles_q <= '0;
      for (int n = 0; n < MEM_SZ; n++) c_mem[n] <= '0;
    end else if (start_req) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      cycles_q <= '0;
    end else if (busy) begin
      cycles_q <= cycles_q + 32'd1;
      if (k_q == LAST) begin
        c_mem[c_idx] <= acc_next;
        acc_q        <= '0;
        k_q          <= '0;
        if (j_q == LAST) begin
          j_q <= '0;
          i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        k_q   <= k_q + 1'b1;
        acc_q <= acc_next;
      end
    end
  end

  // ---------------------------------------------------------------
  // A/B storage: byte-lane gated, frozen while a run is reading them
  // ---------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < MEM_SZ; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
      end
    end else if (wr_req && !busy) begin
      if (sel_a) begin
        if (wbs.wbs_sel_i[0]) a_mem[slot_idx][7:0]        <= wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) a_mem[slot_idx][DATA_W-1:8] <= wbs.wbs_dat_i[DATA_W-1:8];
      end
      if (sel_b) begin
        if (wbs.wbs_sel_i[0]) b_mem[slot_idx][7:0]        <= wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) b_mem[slot_idx][DATA_W-1:8] <= wbs.wbs_dat_i[DATA_W-1:8];
      end
    end
  end

  // ---------------------------------------------------------------
  // Control / status. A run finishing in the same cycle as a DONE
  // clear leaves DONE set, so the completion is never lost.
  // ---------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_req && sel_ctrl) irq_en_q <= wbs.wbs_dat_i[1];
      if (run_last)
        done_q <= 1'b1;
      else if (start_req)
        done_q <= 1'b0;
      else if (wr_req && sel_stat && wbs.wbs_dat_i[1])
        done_q <= 1'b0;
    end
  end

  assign irq_o = done_q & irq_en_q;

  // ---------------------------------------------------------------
  // Read mux and ack / read-data registers
  // ---------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (sel_ctrl)      rdata = {30'd0, irq_en_q, 1'b0};
    else if (sel_stat) rdata = {30'd0, done_q, busy};
    else if (sel_cyc)  rdata = cycles_q;
    else if (sel_a)    rdata = 32'(a_mem[slot_idx]);
    else if (sel_b)    rdata = 32'(b_mem[slot_idx]);
    else if (sel_c)    rdata = 32'(c_mem[slot_idx]);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs.wbs_we_i) ? rdata : 32'd0;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_matmul_wb_accel.sv
// Self-checking bench for matmul_wb_accel: drives the Wishbone interface,
// computes expected C matrices with a plain triple-loop reference model.
module tb_matmul_wb_accel;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  matmul_wb_accel_if wbs();

  matmul_wb_accel #(.N(N), .DATA_W(16), .ACC_W(32), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (wbs),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] a_m [N][N];
  logic signed [15:0] b_m [N][N];
  logic [31:0]        c_m [N][N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = dat;
    wbs.wbs_sel_i = sel;
    acked = 1'b0;
    rd    = '0;
    for (int t = 0; t < 8 && !acked; t++) begin
      @(posedge clk);
      #1;
      if (wbs.wbs_ack_o) begin
        acked = 1'b1;
        rd    = wbs.wbs_dat_o;
      end
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [11:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] rd;
    logic        acked;
    bus_xfer(1'b1, BASE | 32'(off), dat, sel, rd, acked);
    if (!acked) check_eq($sformatf("wr_ack_%03h", off), 32'(acked), 32'd1);
  endtask

  task automatic wb_rd(input logic [11:0] off, output logic [31:0] rd);
    logic acked;
    bus_xfer(1'b0, BASE | 32'(off), 32'd0, 4'hF, rd, acked);
    if (!acked) check_eq($sformatf("rd_ack_%03h", off), 32'(acked), 32'd1);
  endtask

  function automatic logic [11:0] elem_off(input logic [11:0] region, input int i, input int j);
    return region + 12'(4 * (i * N + j));
  endfunction

  task automatic model_compute();
    logic signed [31:0] acc;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc = acc + a_m[i][k] * b_m[k][j];
        c_m[i][j] = acc;
      end
  endtask

  task automatic load_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wb_wr(elem_off(12'h100, i, j), {16'h0, a_m[i][j]});
        wb_wr(elem_off(12'h200, i, j), {16'h0, b_m[i][j]});
      end
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    logic        idle;
    idle = 1'b0;
    for (int p = 0; p < 200 && !idle; p++) begin
      wb_rd(12'h004, st);
      if (st[0] == 1'b0) idle = 1'b1;
    end
    check_eq({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [31:0] rd;
    wb_rd(12'h004, rd);
    check_eq({tag, "_status"}, rd, 32'd2);
    wb_rd(12'h008, rd);
    check_eq({tag, "_cycles"}, rd, 32'(N * N * N));
    model_compute();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        wb_rd(elem_off(12'h300, i, j), rd);
        check_eq($sformatf("%s_c%0d%0d", tag, i, j), rd, c_m[i][j]);
      end
  endtask

  task automatic run_and_check(input string tag, input logic irq_en);
    logic [31:0] rd;
    load_mats();
    wb_wr(12'h000, {30'd0, irq_en, 1'b1});
    wb_rd(12'h004, rd);
    check_eq({tag, "_busy"}, rd, 32'd1);
    wait_idle(tag);
    check_result(tag);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = 16'($urandom);
        b_m[i][j] = 16'($urandom);
      end
  endtask

  initial begin
    logic [31:0] rd;
    logic        acked;

    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = '0;
    wbs.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_eq("rst_irq", 32'(irq), 32'd0);
    wb_rd(12'h004, rd); check_eq("rst_status", rd, 32'd0);
    wb_rd(12'h008, rd); check_eq("rst_cycles", rd, 32'd0);
    wb_rd(12'h300, rd); check_eq("rst_c00", rd, 32'd0);
    bus_xfer(1'b0, BASE | 32'h0FC, 32'd0, 4'hF, rd, acked);
    check_eq("unmapped_ack", 32'(acked), 32'd1);
    check_eq("unmapped_dat", rd, 32'd0);
    bus_xfer(1'b0, BASE | 32'h1000, 32'd0, 4'hF, rd, acked);
    check_eq("miss_noack", 32'(acked), 32'd0);

    // Byte-lane gating on A writes
    wb_wr(12'h100, 32'h0000_1234);
    wb_wr(12'h100, 32'h0000_ABCD, 4'b0001);
    wb_rd(12'h100, rd); check_eq("sel_lo", rd, 32'h0000_12CD);
    wb_wr(12'h100, 32'h0000_ABCD, 4'b0010);
    wb_rd(12'h100, rd); check_eq("sel_hi", rd, 32'hFFFF_ABCD);

    // All 2 x all 3
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = 16'sd2;
        b_m[i][j] = 16'sd3;
      end
    run_and_check("const", 1'b0);
    check_eq("const_c_24", c_m[1][2], 32'd24);
    check_eq("const_noirq", 32'(irq), 32'd0);

    // Identity x ramp
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = (i == j) ? 16'sd1 : 16'sd0;
        b_m[i][j] = 16'(i * 4 + j);
      end
    run_and_check("ident", 1'b0);

    // Signed element
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = 16'sd0;
        b_m[i][j] = 16'sd0;
      end
    a_m[0][0] = 16'hFFFF;
    b_m[0][0] = 16'sd5;
    run_and_check("signed", 1'b0);
    wb_rd(12'h300, rd); check_eq("signed_c00_abs", rd, 32'hFFFF_FFFB);
    wb_rd(12'h100, rd); check_eq("signed_a_sext", rd, 32'hFFFF_FFFF);

    // Wrap with interrupt
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = 16'sh7FFF;
        b_m[i][j] = 16'sh7FFF;
      end
    run_and_check("wrap", 1'b1);
    wb_rd(12'h304, rd); check_eq("wrap_c01_abs", rd, 32'hFFFC_0004);
    check_eq("wrap_irq_set", 32'(irq), 32'd1);
    wb_wr(12'h004, 32'd2);
    check_eq("wrap_irq_clr", 32'(irq), 32'd0);
    wb_rd(12'h004, rd); check_eq("wrap_done_clr", rd, 32'd0);
    wb_wr(12'h000, 32'd0);

    // Random matrices
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      run_and_check($sformatf("rand%0d", r), 1'b0);
    end

    // Busy guards: A write and START ignored, IRQ_EN honoured
    fill_rand();
    load_mats();
    wb_wr(12'h000, 32'd1);
    wb_wr(12'h100, {16'h0, ~a_m[0][0]});
    wb_wr(12'h000, 32'd3);
    wait_idle("guard");
    check_result("guard");
    wb_rd(12'h100, rd); check_eq("guard_a00", rd, 32'(a_m[0][0]));
    check_eq("guard_irq", 32'(irq), 32'd1);
    wb_wr(12'h004, 32'd2);
    check_eq("guard_irq_clr", 32'(irq), 32'd0);

    // Reset mid-run
    wb_wr(12'h000, 32'd3);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    check_eq("mid_irq", 32'(irq), 32'd0);
    wb_rd(12'h004, rd); check_eq("mid_status", rd, 32'd0);
    wb_rd(12'h008, rd); check_eq("mid_cycles", rd, 32'd0);
    wb_rd(12'h000, rd); check_eq("mid_ctrl", rd, 32'd0);
    wb_rd(12'h100, rd); check_eq("mid_a00", rd, 32'd0);
    wb_rd(12'h23C, rd); check_eq("mid_b33", rd, 32'd0);
    wb_rd(12'h300, rd); check_eq("mid_c00", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
